mux_scan_n_1: RTL and testbench

Parametrised N:1 multiplexer with a registered output and an autonomous scan mode. It supersedes the fixed 8:1 combinational mux. In manual mode it forwards the channel chosen by `sel`. In scan mode it steps through the enabled channels round-robin, holding each one for a programmable dwell time. It sits between a bank of channel sources and a single downstream sampler or monitor.

---
 rtl/mux_scan_n_1_if.sv | 30 +++
 rtl/mux_scan_n_1.sv | 146 ++++++++++++++
 tb/tb_mux_scan_n_1.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_n_1_if.sv
// Channel-bank / sampler bundle for mux_scan_n_1.
// The master drives channel data and control; the slave (the mux) returns the selected stream.
interface mux_scan_n_1_if #(
    parameter int N_IN    = 8,
    parameter int DATA_W  = 1,
    parameter int SEL_W   = $clog2(N_IN),
    parameter int DWELL_W = 8
);
    logic [N_IN*DATA_W-1:0] in;
    logic [SEL_W-1:0]       sel;
    logic                   mode;
    logic                   start;
    logic [DWELL_W-1:0]     dwell;
    logic [N_IN-1:0]        mask;
    logic [DATA_W-1:0]      out;
    logic [SEL_W-1:0]       out_sel;
    logic                   valid;
    logic                   busy;
    logic                   wrap;

    modport master (
        output in, sel, mode, start, dwell, mask,
        input  out, out_sel, valid, busy, wrap
    );

    modport slave (
        input  in, sel, mode, start, dwell, mask,
        output out, out_sel, valid, busy, wrap
    );
endinterface

// File: rtl/mux_scan_n_1.sv
// N:1 mux with registered output: manual select, or round-robin scan over masked channels
// with a per-channel dwell. N_IN must be at least 2.
module mux_scan_n_1 #(
    parameter int N_IN    = 8,
    parameter int DATA_W  = 1,
    parameter int SEL_W   = $clog2(N_IN),
    parameter int DWELL_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    mux_scan_n_1_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAN, SCAN} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                wrap_pend_q, wrap_pend_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                wrap_q, wrap_d;
    logic [SEL_W:0]      nxt;

    logic [DATA_W-1:0]   chan [N_IN];

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        assign chan[i] = bus.in[i*DATA_W +: DATA_W];
    end

    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_IN-1:0] m);
        lowest_set = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = SEL_W'(i);
        end
    endfunction

    // MSB set when a channel strictly above cur exists; otherwise the scan wraps.
    function automatic logic [SEL_W:0] next_set(input logic [N_IN-1:0] m,
                                                input logic [SEL_W-1:0] cur);
        next_set = {1'b0, lowest_set(m)};
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (m[i] && (SEL_W'(i) > cur)) next_set = {1'b1, SEL_W'(i)};
        end
    endfunction

    function automatic logic in_range(input logic [SEL_W-1:0] s);
        return int'(s) < N_IN;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        wrap_pend_d = 1'b0;
        out_d       = '0;
        out_sel_d   = '0;
        valid_d     = 1'b0;
        busy_d      = 1'b0;
        wrap_d      = 1'b0;
        nxt         = next_set(bus.mask, ch_q);

        case (state_q)
            IDLE: begin
                if (!bus.mode) begin
                    state_d = MAN;
                end else if (bus.start && (|bus.mask)) begin
                    state_d = SCAN;
                    ch_d    = lowest_set(bus.mask);
                    cnt_d   = bus.dwell;
                    dwell_d = bus.dwell;
                end
            end
            MAN: begin
                if (bus.mode) begin
                    state_d = IDLE;
                end else begin
                    out_sel_d = bus.sel;
                    if (in_range(bus.sel)) begin
                        out_d   = chan[bus.sel];
                        valid_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (!bus.mode) begin
                    state_d = IDLE;
                end else begin
                    out_d     = chan[ch_q];
                    out_sel_d = ch_q;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    // Wrap is flagged at the advance and shown with the new channel one edge later.
                    wrap_d    = wrap_pend_q;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (!(|bus.mask)) begin
                        state_d = IDLE;
                    end else begin
                        ch_d        = nxt[SEL_W-1:0];
                        cnt_d       = dwell_q;
                        wrap_pend_d = ~nxt[SEL_W];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            wrap_pend_q <= 1'b0;
            out_q       <= '0;
            out_sel_q   <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            wrap_pend_q <= wrap_pend_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_sel = out_sel_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan_n_1.sv
// Scoreboard bench for mux_scan_n_1: an 8-channel instance checked through an expectation queue
// and a 6-channel instance for out-of-range manual selects.
module tb_mux_scan_n_1;
    typedef struct {
        string      tag;
        bit         chk;
        logic [6:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb [$];
    exp_t mon_e;
    logic [2:0] s;
    logic [2:0] sparse_seq [12] = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5,
                                    3'd7, 3'd7, 3'd7, 3'd2, 3'd2, 3'd2};

    always #5 clk = ~clk;

    mux_scan_n_1_if #(.N_IN(8), .DATA_W(1), .SEL_W(3), .DWELL_W(8)) if8 ();
    mux_scan_n_1_if #(.N_IN(6), .DATA_W(1), .SEL_W(3), .DWELL_W(8)) if6 ();

    mux_scan_n_1 #(.N_IN(8), .DATA_W(1), .SEL_W(3), .DWELL_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8)
    );
    mux_scan_n_1 #(.N_IN(6), .DATA_W(1), .SEL_W(3), .DWELL_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(if6)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b ({out,out_sel,valid,busy,wrap})", tag, got, exp);
    endtask

    function automatic logic [6:0] ex(input logic o, input logic [2:0] sl,
                                      input logic v, input logic b, input logic w);
        return {o, sl, v, b, w};
    endfunction

    function automatic logic [6:0] pack8();
        return {if8.out, if8.out_sel, if8.valid, if8.busy, if8.wrap};
    endfunction

    function automatic logic [6:0] pack6();
        return {if6.out, if6.out_sel, if6.valid, if6.busy, if6.wrap};
    endfunction

    // Push the expectation for the coming edge, then advance to mid-cycle.
    task automatic cyc(input string tag, input bit chk, input logic [6:0] exp);
        exp_t e;
        e.tag = tag;
        e.chk = chk;
        e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) check(mon_e.tag, 16'(pack8()), 16'(mon_e.exp));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        if8.in = '0; if8.sel = '0; if8.mode = 1'b0; if8.start = 1'b0; if8.dwell = '0; if8.mask = '0;
        if6.in = '0; if6.sel = '0; if6.mode = 1'b0; if6.start = 1'b0; if6.dwell = '0; if6.mask = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_state", 16'(pack8()), 16'd0);
        check("reset_state_n6", 16'(pack6()), 16'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Manual mode
        cyc("idle_to_man", 1, '0);
        if8.in = 8'b00000010; if8.sel = 3'd1;
        if6.in = 6'b111111;   if6.sel = 3'd7;
        cyc("man_sel1", 1, ex(1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
        check("n6_sel7_out_of_range", 16'(pack6()), 16'(ex(1'b0, 3'd7, 1'b0, 1'b0, 1'b0)));
        if8.sel = 3'd2;
        if6.in = 6'b100000; if6.sel = 3'd5;
        cyc("man_sel2", 1, ex(1'b0, 3'd2, 1'b1, 1'b0, 1'b0));
        check("n6_sel5", 16'(pack6()), 16'(ex(1'b1, 3'd5, 1'b1, 1'b0, 1'b0)));
        if8.in = 8'h80; if8.sel = 3'd7;
        if6.in = 6'b101111; if6.sel = 3'd4;
        cyc("man_sel7", 1, ex(1'b1, 3'd7, 1'b1, 1'b0, 1'b0));
        check("n6_sel4", 16'(pack6()), 16'(ex(1'b0, 3'd4, 1'b1, 1'b0, 1'b0)));
        for (int i = 0; i < 6; i++) begin
            if8.in  = 8'($urandom);
            if8.sel = 3'($urandom_range(0, 7));
            cyc("man_rand", 1, ex(if8.in[if8.sel], if8.sel, 1'b1, 1'b0, 1'b0));
        end
        if8.mode = 1'b1;
        cyc("man_to_idle", 1, '0);

        // Full scan, dwell 0
        if8.mask = 8'hFF; if8.dwell = 8'd0; if8.start = 1'b1;
        cyc("full_start", 1, '0);
        if8.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s = 3'(i % 8);
            if8.in = 8'($urandom);
            cyc("full_scan", 1, ex(if8.in[s], s, 1'b1, 1'b1, (i == 8)));
        end
        if8.mode = 1'b0;
        cyc("full_exit", 0, '0);
        if8.mode = 1'b1;
        cyc("toggle_idle", 1, '0);

        // Sparse scan, dwell 2; dwell input changed after start, mask cleared mid-dwell
        if8.mask = 8'b10100100; if8.dwell = 8'd2; if8.start = 1'b1;
        cyc("sparse_start", 1, '0);
        if8.start = 1'b0; if8.dwell = 8'd0;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) if8.mask = '0;
            s = sparse_seq[i];
            if8.in = 8'($urandom);
            cyc("sparse_scan", 1, ex(if8.in[s], s, 1'b1, 1'b1, (i == 9)));
        end
        cyc("sparse_drain", 1, '0);
        cyc("sparse_idle", 1, '0);

        // Start with empty mask is ignored
        if8.mask = '0; if8.start = 1'b1;
        cyc("nomask_start", 1, '0);
        if8.start = 1'b0; if8.mask = 8'hFF;
        cyc("nomask_idle", 1, '0);
        cyc("nomask_idle2", 1, '0);

        // Single channel, dwell 1
        if8.mask = 8'b00010000; if8.dwell = 8'd1; if8.start = 1'b1;
        cyc("single_start", 1, '0);
        if8.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if8.in = 8'($urandom);
            cyc("single_scan", 1, ex(if8.in[4], 3'd4, 1'b1, 1'b1, (i >= 2 && i % 2 == 0)));
        end
        if8.mode = 1'b0;
        cyc("single_exit", 0, '0);
        if8.mode = 1'b1;
        cyc("single_idle", 1, '0);

        // Asynchronous reset during a dwell on channel 5
        if8.mask = 8'b00100000; if8.dwell = 8'd5; if8.start = 1'b1;
        cyc("ch5_start", 1, '0);
        if8.start = 1'b0; if8.in = 8'hFF;
        for (int i = 0; i < 3; i++) cyc("ch5_dwell", 1, ex(1'b1, 3'd5, 1'b1, 1'b1, 1'b0));
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", 16'(pack8()), 16'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("post_rst_idle", 1, '0);
        if8.start = 1'b1;
        cyc("restart", 1, '0);
        if8.start = 1'b0;
        cyc("restart_ch5", 1, ex(1'b1, 3'd5, 1'b1, 1'b1, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
